baud_rate_gen: RTL and testbench

Parametrised, runtime-selectable baud tick generator for the UART transmitter and receiver. A fractional phase accumulator produces an oversampling tick (`os_tick`, OVERSAMPLE × baud) and a bit tick (`b_tick`, 1 × baud). Eight standard rates are selectable at runtime, with no cumulative rate error beyond accumulator quantisation. A `sync` input re-phases both ticks so the receiver can align to a start-bit edge.

---
 rtl/baud_rate_gen.sv | 123 ++++++++++++
 tb/tb_baud_rate_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: fractional phase-accumulator baud tick generator.
// Produces an oversampling tick (os_tick) and a bit tick (b_tick) for eight
// runtime-selectable standard rates. The accumulator remainder carries across
// ticks, so long-run error is bounded by increment rounding only. A sync pulse,
// or any change of baud_sel, restarts both tick phases from zero.
module baud_rate_gen #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sync,
  input  logic [2:0]                    baud_sel,
  output logic                          os_tick,
  output logic                          b_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int unsigned PHASE_W = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(OVERSAMPLE - 1);

  // Rounded phase increment for one rate, evaluated at elaboration in 64 bits.
  function automatic logic [ACC_WIDTH-1:0] calc_inc(input logic [63:0] baud);
    logic [63:0] num;
    logic [63:0] quo;
    num = baud * 64'(OVERSAMPLE) * (64'd1 << ACC_WIDTH) + 64'(CLK_FREQ / 2);
    quo = num / 64'(CLK_FREQ);
    return quo[ACC_WIDTH-1:0];
  endfunction

  localparam logic [ACC_WIDTH-1:0] INC_0 = calc_inc(64'd9600);
  localparam logic [ACC_WIDTH-1:0] INC_1 = calc_inc(64'd19200);
  localparam logic [ACC_WIDTH-1:0] INC_2 = calc_inc(64'd38400);
  localparam logic [ACC_WIDTH-1:0] INC_3 = calc_inc(64'd57600);
  localparam logic [ACC_WIDTH-1:0] INC_4 = calc_inc(64'd115200);
  localparam logic [ACC_WIDTH-1:0] INC_5 = calc_inc(64'd230400);
  localparam logic [ACC_WIDTH-1:0] INC_6 = calc_inc(64'd460800);
  localparam logic [ACC_WIDTH-1:0] INC_7 = calc_inc(64'd921600);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]           sel_q, sel_d;
  logic                 os_tick_q, os_tick_d;
  logic                 b_tick_q, b_tick_d;

  logic [ACC_WIDTH-1:0] inc_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;
  logic                 restart_s;

  // Select the increment of the registered rate; the raw input only triggers a restart.
  always_comb begin
    inc_s = INC_0;
    case (sel_q)
      3'd0:    inc_s = INC_0;
      3'd1:    inc_s = INC_1;
      3'd2:    inc_s = INC_2;
      3'd3:    inc_s = INC_3;
      3'd4:    inc_s = INC_4;
      3'd5:    inc_s = INC_5;
      3'd6:    inc_s = INC_6;
      3'd7:    inc_s = INC_7;
      default: inc_s = INC_0;
    endcase
  end

  // Next-state: restart beats enable; the carry out of the add is the os tick.
  always_comb begin
    acc_d     = acc_q;
    os_cnt_d  = os_cnt_q;
    sel_d     = sel_q;
    os_tick_d = 1'b0;
    b_tick_d  = 1'b0;
    sum_s     = {1'b0, acc_q} + {1'b0, inc_s};
    carry_s   = sum_s[ACC_WIDTH];
    restart_s = sync | (baud_sel != sel_q);
    if (restart_s) begin
      acc_d    = {ACC_WIDTH{1'b0}};
      os_cnt_d = {PHASE_W{1'b0}};
      sel_d    = baud_sel;
    end else if (enable) begin
      acc_d     = sum_s[ACC_WIDTH-1:0];
      os_tick_d = carry_s;
      b_tick_d  = carry_s & (os_cnt_q == LAST_PHASE);
      if (carry_s) begin
        if (os_cnt_q == LAST_PHASE) begin
          os_cnt_d = {PHASE_W{1'b0}};
        end else begin
          os_cnt_d = os_cnt_q + PHASE_W'(1);
        end
      end else begin
        os_cnt_d = os_cnt_q;
      end
    end else begin
      acc_d    = acc_q;
      os_cnt_d = os_cnt_q;
    end
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= {ACC_WIDTH{1'b0}};
      os_cnt_q  <= {PHASE_W{1'b0}};
      sel_q     <= 3'd0;
      os_tick_q <= 1'b0;
      b_tick_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      os_cnt_q  <= os_cnt_d;
      sel_q     <= sel_d;
      os_tick_q <= os_tick_d;
      b_tick_q  <= b_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign b_tick   = b_tick_q;
  assign os_phase = os_cnt_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// tb_baud_rate_gen: scoreboard bench for baud_rate_gen at default parameters.
// Each phase starts at a known restart edge R; the k-th os_tick of that phase
// is expected after enabled edge ceil(k*2^24/inc), with os_phase = k mod 16 and
// b_tick on every 16th. A monitor pops one expectation per visible tick.
module tb_baud_rate_gen;

  localparam int     OS      = 16;
  localparam longint ACC_MOD = longint'(1) << 24;
  localparam longint INC0    = 25770;
  localparam longint INC4    = 309238;
  localparam longint INC7    = 2473901;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sync;
  logic [2:0] baud_sel;
  logic       os_tick;
  logic       b_tick;
  logic [3:0] os_phase;

  baud_rate_gen dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sync     (sync),
    .baud_sel (baud_sel),
    .os_tick  (os_tick),
    .b_tick   (b_tick),
    .os_phase (os_phase)
  );

  typedef struct {
    int         cyc;
    logic       b;
    logic [3:0] ph;
  } tick_t;

  tick_t sb[$];
  tick_t mon_e;
  int    cyc      = 0;
  int    n_cmp    = 0;
  int    n_fail   = 0;
  int    first_os = -1;
  int    first_b  = -1;
  int    b_count  = 0;
  int    phase_r  = 0;
  int    r;
  int    r_next;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count active edges since time zero.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every visible tick must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (os_tick || b_tick)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: cycle %0d os_tick=%b b_tick=%b os_phase=%0d, expected no tick",
                 cyc, os_tick, b_tick, os_phase);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || os_tick !== 1'b1 || b_tick !== mon_e.b || os_phase !== mon_e.ph) begin
          n_fail++;
          $display("FAIL tick: got cycle %0d os=%b b=%b ph=%0d, expected cycle %0d os=1 b=%b ph=%0d",
                   cyc, os_tick, b_tick, os_phase, mon_e.cyc, mon_e.b, mon_e.ph);
        end
      end
      if (os_tick && first_os < 0) first_os = cyc;
      if (b_tick && first_b < 0) first_b = cyc;
      if (b_tick) b_count++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected ticks of one phase; stride 2 models enable high on every other edge.
  task automatic push_stream(input int rs, input longint inc, input int stride, input int end_excl);
    longint n;
    int     c;
    tick_t  t;
    for (int k = 1; k < 100000; k++) begin
      n = (longint'(k) * ACC_MOD + inc - 1) / inc;
      c = rs + stride * int'(n) - (stride - 1);
      if (c >= end_excl) break;
      t.cyc = c;
      t.b   = ((k % OS) == 0);
      t.ph  = 4'(k % OS);
      sb.push_back(t);
    end
  endtask

  task automatic begin_phase(input int rs, input longint inc, input int stride, input int end_excl);
    check("drain", sb.size(), 0);
    sb.delete();
    first_os = -1;
    first_b  = -1;
    b_count  = 0;
    phase_r  = rs;
    push_stream(rs, inc, stride, end_excl);
  endtask

  task automatic check_marks(input int exp_os, input int exp_b);
    check("first_os_offset", (first_os < 0) ? -1 : first_os - phase_r, exp_os);
    check("first_b_offset", (first_b < 0) ? -1 : first_b - phase_r, exp_b);
  endtask

  // Make edge rs a restart edge (sync pulse and/or new baud_sel), return after its negedge.
  task automatic restart_at(input int rs, input logic use_sync, input logic [2:0] sel);
    wait_to_cycle(rs - 1);
    sync     = use_sync;
    baud_sel = sel;
    @(posedge clk);
    #1;
    sync = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    sync     = 1'b0;
    baud_sel = 3'd0;

    wait_to_cycle(3);
    check("reset_os_tick", int'(os_tick), 0);
    check("reset_b_tick", int'(b_tick), 0);
    check("reset_os_phase", int'(os_phase), 0);
    check("reset_acc", int'(dut.acc_q), 0);
    check("reset_sel", int'(dut.sel_q), 0);
    reset = 1'b0;

    // sel0, continuous enable.
    r = 3;
    begin_phase(r, INC0, 1, r + 21000);

    // sel4 rate.
    r_next = r + 21000;
    restart_at(r_next, 1'b0, 3'd4);
    check_marks(652, 10417);
    r = r_next;
    begin_phase(r, INC4, 1, r + 10000);

    // sel0 with enable at 50% duty.
    r_next = r + 10000;
    restart_at(r_next, 1'b0, 3'd0);
    check_marks(55, 869);
    check("sel4_b_count", b_count, 11);
    r = r_next;
    begin_phase(r, INC0, 2, r + 21000);
    while (cyc < r + 21000 - 1) begin
      @(posedge clk);
      #1;
      enable = ((cyc - r) % 2 == 0);
    end
    enable = 1'b1;

    // sync restart, then a second sync on the would-be first carry edge.
    r_next = r + 21000;
    restart_at(r_next, 1'b1, 3'd0);
    check_marks(1303, 20833);
    r = r_next;
    begin_phase(r, INC0, 1, r + 652);
    r_next = r + 652;
    restart_at(r_next, 1'b1, 3'd0);
    check("sync_carry_ticks", int'({os_tick, b_tick}), 0);
    check("sync_carry_acc", int'(dut.acc_q), 0);
    check_marks(-1, -1);
    r = r_next;
    begin_phase(r, INC0, 1, r + 4600);

    // sync at os_phase 7.
    wait_to_cycle(r + 4599);
    check("pre_sync_phase", int'(os_phase), 7);
    r_next = r + 4600;
    restart_at(r_next, 1'b1, 3'd0);
    check("post_sync_phase", int'(os_phase), 0);
    check("post_sync_ticks", int'({os_tick, b_tick}), 0);
    check("post_sync_acc", int'(dut.acc_q), 0);
    check_marks(652, -1);
    r = r_next;
    begin_phase(r, INC0, 1, r + 11000);

    // baud_sel 0 -> 7 mid-bit.
    r_next = r + 11000;
    restart_at(r_next, 1'b0, 3'd7);
    check("sel_change_ticks", int'({os_tick, b_tick}), 0);
    check("sel_change_phase", int'(os_phase), 0);
    check_marks(652, 10417);
    r = r_next;
    begin_phase(r, INC7, 1, r + 1000);

    // Reset asserted at os_phase 12, released with baud_sel 4.
    r_next = r + 1000;
    restart_at(r_next, 1'b1, 3'd7);
    check_marks(7, 109);
    r = r_next;
    begin_phase(r, INC7, 1, r + 86);
    wait_to_cycle(r + 85);
    check("pre_reset_phase", int'(os_phase), 12);
    reset = 1'b1;
    #1;
    check("in_reset_ticks", int'({os_tick, b_tick}), 0);
    check("in_reset_phase", int'(os_phase), 0);
    baud_sel = 3'd4;
    check_marks(7, -1);
    wait_to_cycle(r + 88);
    reset = 1'b0;
    r_next = r + 89;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("post_reset_restart_acc", int'(dut.acc_q), 0);
    check("post_reset_restart_sel", int'(dut.sel_q), 4);
    r = r_next;
    begin_phase(r, INC4, 1, r + 2000);
    wait_to_cycle(r + 2000);
    @(negedge clk);
    #1;
    check_marks(55, 869);
    check("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
